pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage opcode into a 9-bit control word and carries it through internal ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles using a parametrised stall FSM. Handles branch/jump flush.
- Sits between the IF/ID register and the datapath stage registers; drives PC and IF/ID write enables.

Parameters:
- REG_AW, 5, register-address width for rs/rt hazard compare.
- LOAD_LAT, 1, stall cycles per load-use hazard; legal range 1..7.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- op_i  input  6  opcode of the instruction in ID.
- id_rs_i  input  REG_AW  rs field of the ID instruction.
- id_rt_i  input  REG_AW  rt field of the ID instruction.
- flush_i  input  1  kill the ID instruction (taken branch/jump resolved).
- ex_ctrl_o  output  4  ID/EX EX bits: {RegDst, ALUOp[1:0], ALUSrc}.
- mem_ctrl_o  output  3  EX/MEM M bits: {Branch, MemRead, MemWrite}.
- wb_ctrl_o  output  2  MEM/WB WB bits: {RegWrite, MemtoReg}.
- branch_o  output  1  combinational decode: beq in ID.
- jump_o  output  1  combinational decode: j in ID.
- illegal_o  output  1  combinational: opcode not recognised.
- stall_o  output  1  hazard stall active this cycle.
- pc_write_o  output  1  equals ~stall_o.
- ifid_write_o  output  1  equals ~stall_o.
- stall_cnt_o  output  CNT_W  stall-cycle counter (optional feature).
- flush_cnt_o  output  CNT_W  flush counter (optional feature).

Behaviour:
- Decode (combinational, 9-bit word {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp, ALUSrc}):
  - R-type 000000: 1,0,0,0,0,1,10,0.
  - lw 100011: 1,1,0,1,0,0,00,1.
  - sw 101011: 0,0,0,0,1,0,00,1.
  - beq 000100: 0,0,1,0,0,0,01,0.
  - j 000010: all zero; jump_o=1.
  - addi 001000: 1,0,0,0,0,0,00,1.
  - Any other opcode: all zero; illegal_o=1.
  - Don't-cares are driven 0; no X on any output.
- Pipelining:
  - ID/EX holds the full 9-bit word plus the rt address.
  - EX/MEM holds the M and WB bits; MEM/WB holds the WB bits.
  - EX/MEM and MEM/WB advance every cycle, never stalled.
  - Latency from ID: ex_ctrl_o 1 cycle, mem_ctrl_o 2 cycles, wb_ctrl_o 3 cycles.
- Hazard condition: hz = idex_MemRead & (idex_rt != 0) & (idex_rt == id_rs_i | idex_rt == id_rt_i).
- FSM state RUN:
  - hz=1 and flush_i=0: stall_o=1 and a bubble (all-zero word) is loaded into ID/EX.
  - If LOAD_LAT>1 in that case, go to STALL with cnt=LOAD_LAT-1; otherwise stay in RUN.
  - hz=0: ID/EX loads the decoded word.
- FSM state STALL:
  - stall_o=1; a bubble is loaded into ID/EX each cycle; cnt decrements.
  - Return to RUN in the cycle cnt reaches 1 (that cycle still stalls).
  - Total stall per hazard is exactly LOAD_LAT cycles.
- Flush:
  - flush_i=1 has priority over everything: ID/EX loads a bubble, stall_o=0, and the FSM is forced to RUN with cnt=0.
  - This applies in both RUN and STALL.
- Simultaneous hz and flush_i: treated as a flush. No stall is counted; the flush is counted.
- Reset (asynchronous, any time including mid-stall):
  - All stage registers are cleared to zero, FSM goes to RUN, cnt=0, counters=0.
  - Effect on outputs: ex/mem/wb_ctrl_o=0, stall_o=0, pc_write_o=ifid_write_o=1.
  - branch_o, jump_o and illegal_o follow op_i combinationally, even during reset.

Optional Feature:
- PIPE_CTRL_PERF_CNT_EN defined:
  - stall_cnt_o increments once per cycle with stall_o=1.
  - flush_cnt_o increments once per cycle with flush_i=1.
  - Both counters saturate at all-ones and clear on reset.
- Macro undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Reset, then op_i=000000 held -> after 1 cycle ex_ctrl_o=4'b1100; after 2 cycles mem_ctrl_o=3'b000; after 3 cycles wb_ctrl_o=2'b10.
- lw rt=5 followed by add with rs=5, LOAD_LAT=1 -> stall_o=1 for exactly 1 cycle; pc_write_o=0 that cycle; ex_ctrl_o=0 on the next cycle (bubble).
- Same sequence with LOAD_LAT=3 -> stall_o high for 3 consecutive cycles, then add's ex_ctrl_o=4'b1100 appears.
- lw rt=0 followed by use of r0 -> no stall. op_i=111111 -> illegal_o=1 and all control zero downstream.
- flush_i=1 during the second cycle of a LOAD_LAT=3 stall -> stall_o=0 immediately and FSM back in RUN. With the macro defined, flush_cnt_o=1 and stall_cnt_o=1.
- rst_i pulsed low mid-stall (asynchronously, between clock edges) -> outputs zero immediately and stall_o=0. With the macro defined and CNT_W=2, 5 stall cycles -> stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// Bus between the ID stage and the pipeline control unit.
// The master drives the ID instruction fields; the slave returns the staged control bits.
interface pipe_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [5:0]        op_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              flush_i;
    logic [3:0]        ex_ctrl_o;
    logic [2:0]        mem_ctrl_o;
    logic [1:0]        wb_ctrl_o;
    logic              branch_o;
    logic              jump_o;
    logic              illegal_o;
    logic              stall_o;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output op_i, id_rs_i, id_rt_i, flush_i,
        input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, branch_o, jump_o, illegal_o,
        input  stall_o, pc_write_o, ifid_write_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  op_i, id_rs_i, id_rt_i, flush_i,
        output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, branch_o, jump_o, illegal_o,
        output stall_o, pc_write_o, ifid_write_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: opcode decode, ID/EX-EX/MEM-MEM/WB control staging, load-use stall FSM, flush.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_ctrl_unit_if.slave   bus
);
    // Control word layout: {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp[1:0], ALUSrc}
    localparam logic [8:0] W_RTYPE = 9'b1_0_0_0_0_1_10_0;
    localparam logic [8:0] W_LW    = 9'b1_1_0_1_0_0_00_1;
    localparam logic [8:0] W_SW    = 9'b0_0_0_0_1_0_00_1;
    localparam logic [8:0] W_BEQ   = 9'b0_0_1_0_0_0_01_0;
    localparam logic [8:0] W_ADDI  = 9'b1_0_0_0_0_0_00_1;
    localparam logic [2:0] LAT_M1  = 3'(LOAD_LAT - 1);

    typedef enum logic {RUN, STALL} state_t;

    logic [8:0]        dec_word;
    logic              dec_branch;
    logic              dec_jump;
    logic              dec_illegal;

    logic [8:0]        idex_word_q, idex_word_d;
    logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
    logic [4:0]        exmem_q;
    logic [1:0]        memwb_q;
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              hz;
    logic              stall;
    logic              bubble;

    always_comb begin
        dec_word    = 9'b0;
        dec_branch  = 1'b0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;
        case (bus.op_i)
            6'b000000: dec_word = W_RTYPE;
            6'b100011: dec_word = W_LW;
            6'b101011: dec_word = W_SW;
            6'b000100: begin
                dec_word   = W_BEQ;
                dec_branch = 1'b1;
            end
            6'b000010: dec_jump = 1'b1;
            6'b001000: dec_word = W_ADDI;
            default:   dec_illegal = 1'b1;
        endcase
    end

    assign hz = idex_word_q[5] && (idex_rt_q != '0) &&
                ((idex_rt_q == bus.id_rs_i) || (idex_rt_q == bus.id_rt_i));

    // Stall FSM; a flush overrides any hazard or stall in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        if (bus.flush_i) begin
            bubble  = 1'b1;
            state_d = RUN;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = LAT_M1;
                        end
                    end
                end
                STALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        idex_word_d = dec_word;
        idex_rt_d   = bus.id_rt_i;
        if (bubble) begin
            idex_word_d = 9'b0;
            idex_rt_d   = '0;
        end
    end

    // ID/EX -> EX/MEM -> MEM/WB; the downstream stages never stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_word_q <= 9'b0;
            idex_rt_q   <= '0;
            exmem_q     <= 5'b0;
            memwb_q     <= 2'b0;
            state_q     <= RUN;
            cnt_q       <= 3'd0;
        end else begin
            idex_word_q <= idex_word_d;
            idex_rt_q   <= idex_rt_d;
            exmem_q     <= idex_word_q[8:4];
            memwb_q     <= exmem_q[4:3];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ex_ctrl_o    = idex_word_q[3:0];
    assign bus.mem_ctrl_o   = exmem_q[2:0];
    assign bus.wb_ctrl_o    = memwb_q;
    assign bus.branch_o     = dec_branch;
    assign bus.jump_o       = dec_jump;
    assign bus.illegal_o    = dec_illegal;
    assign bus.stall_o      = stall;
    assign bus.pc_write_o   = ~stall;
    assign bus.ifid_write_o = ~stall;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        stall_cnt_d = stall       ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = bus.flush_i ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
    assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one LOAD_LAT=1 instance and one LOAD_LAT=3/CNT_W=2 instance share stimulus.
module tb_pipe_ctrl_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) b1 ();
    pipe_ctrl_unit_if #(.REG_AW(5), .CNT_W(2))  b3 ();

    pipe_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u1 (
        .clk_i(clk), .rst_i(rst_n), .bus(b1.slave)
    );
    pipe_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(2)) u3 (
        .clk_i(clk), .rst_i(rst_n), .bus(b3.slave)
    );

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic fl);
        b1.op_i = op; b1.id_rs_i = rs; b1.id_rt_i = rt; b1.flush_i = fl;
        b3.op_i = op; b3.id_rs_i = rs; b3.id_rt_i = rt; b3.flush_i = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held: outputs cleared, decode still live.
        drive(6'b000000, 5'd0, 5'd0, 1'b0);
        chk("rst_ex",    32'(b1.ex_ctrl_o), 32'h0);
        chk("rst_mem",   32'(b1.mem_ctrl_o), 32'h0);
        chk("rst_wb",    32'(b1.wb_ctrl_o), 32'h0);
        chk("rst_stall", 32'(b1.stall_o), 32'h0);
        chk("rst_pcw",   32'(b1.pc_write_o), 32'h1);
        chk("rst_ifidw", 32'(b1.ifid_write_o), 32'h1);
        drive(6'b111111, 5'd0, 5'd0, 1'b0);
        chk("rst_illegal", 32'(b1.illegal_o), 32'h1);
        drive(6'b000000, 5'd0, 5'd0, 1'b0);
        chk("rst_legal", 32'(b1.illegal_o), 32'h0);
        #6 rst_n = 1'b1;

        // R-type latency through the stages.
        tick();
        chk("r_ex1",  32'(b1.ex_ctrl_o), 32'hC);
        chk("r_mem1", 32'(b1.mem_ctrl_o), 32'h0);
        chk("r_wb1",  32'(b1.wb_ctrl_o), 32'h0);
        tick();
        chk("r_mem2", 32'(b1.mem_ctrl_o), 32'h0);
        chk("r_wb2",  32'(b1.wb_ctrl_o), 32'h0);
        tick();
        chk("r_wb3",  32'(b1.wb_ctrl_o), 32'h2);

        // lw r5 then add using r5.
        drive(6'b100011, 5'd0, 5'd5, 1'b0);
        chk("lw_nostall", 32'(b1.stall_o), 32'h0);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b0);
        chk("lw_ex",       32'(b1.ex_ctrl_o), 32'h1);
        chk("l1_stall",    32'(b1.stall_o), 32'h1);
        chk("l1_pcw",      32'(b1.pc_write_o), 32'h0);
        chk("l1_ifidw",    32'(b1.ifid_write_o), 32'h0);
        chk("l3_stall_c1", 32'(b3.stall_o), 32'h1);
        tick();
        chk("l1_bubble",   32'(b1.ex_ctrl_o), 32'h0);
        chk("l1_stall_off",32'(b1.stall_o), 32'h0);
        chk("l1_lw_mem",   32'(b1.mem_ctrl_o), 32'h2);
        chk("l3_stall_c2", 32'(b3.stall_o), 32'h1);
        tick();
        chk("l1_add_ex",   32'(b1.ex_ctrl_o), 32'hC);
        chk("l3_stall_c3", 32'(b3.stall_o), 32'h1);
        chk("l3_bubble",   32'(b3.ex_ctrl_o), 32'h0);
        tick();
        chk("l3_stall_off",32'(b3.stall_o), 32'h0);
        chk("l3_pcw",      32'(b3.pc_write_o), 32'h1);
        tick();
        chk("l3_add_ex",   32'(b3.ex_ctrl_o), 32'hC);

        // lw to r0 never creates a hazard.
        drive(6'b100011, 5'd0, 5'd0, 1'b0);
        tick();
        drive(6'b000000, 5'd0, 5'd0, 1'b0);
        chk("r0_stall_l1", 32'(b1.stall_o), 32'h0);
        chk("r0_stall_l3", 32'(b3.stall_o), 32'h0);
        tick();
        drive(6'b111111, 5'd0, 5'd0, 1'b0);
        chk("ill_flag",   32'(b1.illegal_o), 32'h1);
        chk("ill_branch", 32'(b1.branch_o), 32'h0);
        chk("ill_jump",   32'(b1.jump_o), 32'h0);
        tick();
        chk("ill_ex", 32'(b1.ex_ctrl_o), 32'h0);
        tick();
        chk("ill_mem", 32'(b1.mem_ctrl_o), 32'h0);
        chk("r_wb_prev", 32'(b1.wb_ctrl_o), 32'h2);
        tick();
        chk("ill_wb", 32'(b1.wb_ctrl_o), 32'h0);

        // beq and j decode.
        drive(6'b000100, 5'd0, 5'd0, 1'b0);
        chk("beq_branch", 32'(b1.branch_o), 32'h1);
        chk("beq_jump",   32'(b1.jump_o), 32'h0);
        tick();
        chk("beq_ex", 32'(b1.ex_ctrl_o), 32'h2);
        drive(6'b000010, 5'd0, 5'd0, 1'b0);
        chk("j_jump",    32'(b1.jump_o), 32'h1);
        chk("j_illegal", 32'(b1.illegal_o), 32'h0);
        tick();
        chk("j_ex",    32'(b1.ex_ctrl_o), 32'h0);
        chk("beq_mem", 32'(b1.mem_ctrl_o), 32'h4);

        // Asynchronous reset in the middle of a LOAD_LAT=3 stall.
        drive(6'b100011, 5'd0, 5'd5, 1'b0);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b0);
        chk("ar_stall_pre", 32'(b3.stall_o), 32'h1);
        tick();
        chk("ar_stall_mid", 32'(b3.stall_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_stall", 32'(b3.stall_o), 32'h0);
        chk("ar_ex",    32'(b3.ex_ctrl_o), 32'h0);
        chk("ar_mem",   32'(b3.mem_ctrl_o), 32'h0);
        chk("ar_wb",    32'(b3.wb_ctrl_o), 32'h0);
        chk("ar_pcw",   32'(b3.pc_write_o), 32'h1);
        chk("ar_scnt",  32'(b3.stall_cnt_o), 32'h0);
        #1 rst_n = 1'b1;

        // Flush in the second cycle of a LOAD_LAT=3 stall.
        tick();
        drive(6'b100011, 5'd0, 5'd5, 1'b0);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b0);
        chk("fl_stall_c1", 32'(b3.stall_o), 32'h1);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b1);
        chk("fl_stall_now", 32'(b3.stall_o), 32'h0);
        chk("fl_pcw",       32'(b3.pc_write_o), 32'h1);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b0);
        chk("fl_bubble", 32'(b3.ex_ctrl_o), 32'h0);
        chk("fl_run",    32'(b3.stall_o), 32'h0);
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("fl_scnt", 32'(b3.stall_cnt_o), 32'h1);
        chk("fl_fcnt", 32'(b3.flush_cnt_o), 32'h1);
`else
        chk("fl_scnt_tied", 32'(b3.stall_cnt_o), 32'h0);
        chk("fl_fcnt_tied", 32'(b3.flush_cnt_o), 32'h0);
`endif
        tick();
        chk("fl_add_ex", 32'(b3.ex_ctrl_o), 32'hC);

        // Second full stall drives the 2-bit stall counter to saturation.
        drive(6'b100011, 5'd0, 5'd5, 1'b0);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b0);
        tick();
        tick();
        tick();
        chk("sat_stall_off", 32'(b3.stall_o), 32'h0);
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("sat_scnt", 32'(b3.stall_cnt_o), 32'h3);
        chk("sat_fcnt", 32'(b3.flush_cnt_o), 32'h1);
`else
        chk("sat_scnt_tied", 32'(b3.stall_cnt_o), 32'h0);
`endif

        // Hazard and flush together: flush wins, no stall.
        tick();
        drive(6'b100011, 5'd0, 5'd5, 1'b0);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b1);
        chk("hzfl_stall_l3", 32'(b3.stall_o), 32'h0);
        chk("hzfl_stall_l1", 32'(b1.stall_o), 32'h0);
        tick();
        drive(6'b000000, 5'd5, 5'd6, 1'b0);
        chk("hzfl_bubble", 32'(b3.ex_ctrl_o), 32'h0);
        chk("hzfl_run",    32'(b3.stall_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
